// File: rtl/ransac_fixed.sv
`default_nettype none
// ============================================================================
//  Module      : ransac_fixed (package)
//  Description : Shared signed Q16.16 fixed-point type and helpers used by
//                the RANSAC normalisation path.
//  Revision    : 1.0  initial release
// ============================================================================
package ransac_fixed;

   localparam int FRACTION_BITS = 16;
   localparam int VALUE_BITS    = 32;

   typedef logic signed [VALUE_BITS-1:0] fixed_t;

   function automatic int fraction_bits();
      return FRACTION_BITS;
   endfunction

   function automatic int value_bits();
      return VALUE_BITS;
   endfunction

   function automatic fixed_t one();
      return fixed_t'(1) << FRACTION_BITS;
   endfunction

   function automatic fixed_t max_positive();
      return {1'b0, {(VALUE_BITS-1){1'b1}}};
   endfunction

   // Bit index of the most significant set bit, or -1 for an all-zero value.
   function automatic int leading_one_index(fixed_t value);
      int index;
      index = -1;
      for (int i = 0; i < VALUE_BITS; i++) begin
         if (value[i]) index = i;
      end
      return index;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rsqrt_newton_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rsqrt_newton_sequencer_pkg (package)
//  Description : State encoding for the Newton rsqrt request sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package rsqrt_newton_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SEED  = 3'd1,
      ST_ISSUE = 3'd2,
      ST_WAIT  = 3'd3,
      ST_DONE  = 3'd4
   } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/rsqrt_newton_sequencer_seed.sv
`default_nettype none
// ============================================================================
//  Module      : rsqrt_seed_generator
//  Description : Combinational power-of-two seed for 1/sqrt(x): finds the
//                leading one of x, halves the negated exponent (floor) and
//                shifts one() accordingly, saturating on overflow.
//  Revision    : 1.0  initial release
// ============================================================================
module rsqrt_seed_generator
   import ransac_fixed::*;
(
   input  fixed_t number,
   output fixed_t seed
);

   int msb_index;
   int neg_exponent;
   int shift;

   // Seed = 2^floor(-(p - F)/2); arithmetic shift of a signed int floors.
   always_comb begin
      msb_index    = leading_one_index(number);
      neg_exponent = fraction_bits() - msb_index;
      shift        = neg_exponent >>> 1;
      if (msb_index < 0) begin
         // Zero never reaches the seed stage; pick a harmless saturated value.
         seed = max_positive();
      end else if (shift >= 0) begin
         // The one-bit must stay below the sign bit.
         if (fraction_bits() + shift > value_bits() - 2) begin
            seed = max_positive();
         end else begin
            seed = one() << shift;
         end
      end else begin
         seed = one() >> (-shift);
      end
   end

endmodule
`default_nettype wire

// File: rtl/rsqrt_newton_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : rsqrt_newton_sequencer
//  Description : Initiator for an external Newton rsqrt iteration unit.
//                Seeds a power-of-two guess, runs up to ITERATIONS passes
//                with a per-pass timeout, and returns 1/sqrt(x).
//  Revision    : 1.0  initial release
// ============================================================================
module rsqrt_newton_sequencer
   import ransac_fixed::*;
   import rsqrt_newton_sequencer_pkg::*;
#(
   parameter int ITERATIONS     = 4,
   parameter int TIMEOUT_CYCLES = 64,
   parameter int RESET_POLARITY = 1
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic                              input_valid,
   input  fixed_t                            number,
   output logic                              input_ready,
   output logic                              output_valid,
   output fixed_t                            result,
   output logic                              error,
   output logic [$clog2(ITERATIONS+1)-1:0]   iterations_used,
   output logic                              iter_input_valid,
   output fixed_t                            iter_number,
   output fixed_t                            iter_old_guess,
   input  logic                              iter_input_ready,
   input  logic                              iter_output_valid,
   input  fixed_t                            iter_new_guess
);

   localparam int COUNT_W = $clog2(ITERATIONS + 1);
   localparam int WAIT_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [COUNT_W-1:0] LAST_PASS = COUNT_W'(ITERATIONS - 1);
   localparam logic [WAIT_W-1:0]  LAST_WAIT = WAIT_W'(TIMEOUT_CYCLES - 1);

   // Reset is always synchronous active-high; the polarity setting is inert.
   if (RESET_POLARITY == 0) begin : g_reset_polarity_fixed
   end

   seq_state_t            state;
   seq_state_t            next_state;
   fixed_t                x_latched;
   fixed_t                guess;
   fixed_t                seed;
   fixed_t                pending_result;
   logic                  pending_error;
   logic [COUNT_W-1:0]    pass_count;
   logic [WAIT_W-1:0]     wait_count;

   logic                  x_not_positive;
   logic                  capture;
   logic                  new_is_negative;
   logic                  converged;
   logic                  timed_out;

   rsqrt_seed_generator seed_gen (
      .number (x_latched),
      .seed   (seed)
   );

   assign x_not_positive  = (number <= fixed_t'(0));
   // The first WAIT cycle (wait_count==0) ignores a possibly stale valid.
   assign capture         = (wait_count != '0) && iter_output_valid;
   assign new_is_negative = iter_new_guess[VALUE_BITS-1];
   assign converged       = (iter_new_guess == guess) || (pass_count == LAST_PASS);
   assign timed_out       = (wait_count == LAST_WAIT);

   assign iter_number     = x_latched;
   assign iter_old_guess  = guess;

   // State register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state decode.
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: begin
            if (input_valid) begin
               next_state = x_not_positive ? ST_DONE : ST_SEED;
            end
         end
         ST_SEED:  next_state = ST_ISSUE;
         ST_ISSUE: begin
            if (iter_input_ready) next_state = ST_WAIT;
         end
         ST_WAIT: begin
            if (capture) begin
               next_state = (new_is_negative || converged) ? ST_DONE : ST_ISSUE;
            end else if (timed_out) begin
               next_state = ST_DONE;
            end
         end
         ST_DONE:  next_state = ST_IDLE;
         default:  next_state = ST_IDLE;
      endcase
   end

   // Moore handshake outputs.
   always_comb begin
      input_ready      = 1'b0;
      iter_input_valid = 1'b0;
      case (state)
         ST_IDLE:  input_ready      = 1'b1;
         ST_ISSUE: iter_input_valid = 1'b1;
         default: begin
            input_ready      = 1'b0;
            iter_input_valid = 1'b0;
         end
      endcase
   end

   // Datapath: operand latch, guess, pass/timeout counters and result registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         x_latched       <= '0;
         guess           <= '0;
         pending_result  <= '0;
         pending_error   <= 1'b0;
         pass_count      <= '0;
         wait_count      <= '0;
         output_valid    <= 1'b0;
         error           <= 1'b0;
         result          <= '0;
         iterations_used <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (input_valid) begin
                  x_latched      <= number;
                  output_valid   <= 1'b0;
                  error          <= 1'b0;
                  pass_count     <= '0;
                  pending_error  <= x_not_positive;
                  pending_result <= '0;
               end
            end
            ST_SEED: begin
               guess         <= seed;
               pass_count    <= '0;
               wait_count    <= '0;
               pending_error <= 1'b0;
            end
            ST_ISSUE: begin
               wait_count <= '0;
            end
            ST_WAIT: begin
               if (capture) begin
                  pass_count <= pass_count + 1'b1;
                  wait_count <= '0;
                  if (new_is_negative) begin
                     pending_error  <= 1'b1;
                     pending_result <= '0;
                  end else if (converged) begin
                     pending_error  <= 1'b0;
                     pending_result <= iter_new_guess;
                  end else begin
                     guess <= iter_new_guess;
                  end
               end else begin
                  wait_count <= wait_count + 1'b1;
                  if (timed_out) begin
                     pending_error  <= 1'b1;
                     pending_result <= guess;
                  end
               end
            end
            ST_DONE: begin
               output_valid    <= 1'b1;
               result          <= pending_result;
               error           <= pending_error;
               iterations_used <= pass_count;
            end
            default: begin
               output_valid <= output_valid;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_rsqrt_newton_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rsqrt_newton_sequencer
//  Description : Scoreboard bench with a latency-5 Newton iteration unit model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rsqrt_newton_sequencer;
   import ransac_fixed::*;

   localparam int ITERS    = 4;
   localparam int TMO      = 64;
   localparam int UNIT_LAT = 5;

   logic   clock = 1'b0;
   logic   reset = 1'b1;
   logic   input_valid = 1'b0;
   fixed_t number = '0;
   logic   input_ready, output_valid, error, iter_input_valid;
   fixed_t result, iter_number, iter_old_guess;
   logic [2:0] iterations_used;
   logic   iter_input_ready = 1'b0;
   logic   iter_output_valid = 1'b0;
   fixed_t iter_new_guess = '0;

   rsqrt_newton_sequencer #(
      .ITERATIONS     (ITERS),
      .TIMEOUT_CYCLES (TMO),
      .RESET_POLARITY (1)
   ) dut (
      .clock             (clock),
      .reset             (reset),
      .input_valid       (input_valid),
      .number            (number),
      .input_ready       (input_ready),
      .output_valid      (output_valid),
      .result            (result),
      .error             (error),
      .iterations_used   (iterations_used),
      .iter_input_valid  (iter_input_valid),
      .iter_number       (iter_number),
      .iter_old_guess    (iter_old_guess),
      .iter_input_ready  (iter_input_ready),
      .iter_output_valid (iter_output_valid),
      .iter_new_guess    (iter_new_guess)
   );

   always #5 clock = ~clock;

   typedef struct {
      int    exp_result;
      int    tol;
      bit    exp_error;
      int    exp_iters;
      int    lat_mode;   // 0 none, 1 from request cycle, 2 from first WAIT cycle
      int    lat;
      int    accept_cyc;
      int    iv_snap;
      string name;
   } exp_t;

   exp_t sb[$];
   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int hs_cyc = 0;
   int hs_count = 0;
   int iv_count = 0;
   int mode = 0;       // 0 normal, 1 never answer, 2 answer negative
   bit flush = 1'b0;
   bit     ubusy = 1'b0;
   int     ucnt = 0;
   fixed_t ux = '0;
   fixed_t ug = '0;

   always @(posedge clock) begin
      cyc <= cyc + 1;
      if (iter_input_valid && iter_input_ready) begin
         hs_cyc   <= cyc + 1;
         hs_count <= hs_count + 1;
      end
   end

   task automatic check(input string name, input longint actual, input longint expected);
      tests++;
      if (actual != expected) begin
         fails++;
         $display("FAIL %s: actual %0d required %0d", name, actual, expected);
      end
   endtask

   // One Newton step 0.5*g*(3 - x*g*g) in Q16.16, truncating.
   function automatic fixed_t unit_step(fixed_t x, fixed_t g);
      longint gg, xgg, t, r;
      gg  = (longint'(g) * longint'(g)) >>> 16;
      xgg = (longint'(x) * gg) >>> 16;
      t   = (longint'(3) <<< 16) - xgg;
      r   = (longint'(g) * t) >>> 17;
      return fixed_t'(r);
   endfunction

   // Reference: seed 2^floor(-floor(log2 x)/2), then iterate to convergence.
   function automatic void ref_rsqrt(input fixed_t x, output int res, output bit err, output int iters);
      int e, k;
      fixed_t g, n;
      res = 0; err = 1'b1; iters = 0;
      if (x <= 0) return;
      e = $clog2(longint'(x) + 1) - 1 - 16;
      k = $rtoi($floor(-e / 2.0));
      if (k > 14) g = 32'sh7fff_ffff;
      else g = fixed_t'($rtoi((2.0 ** k) * 65536.0));
      for (int p = 1; p <= ITERS; p++) begin
         n = unit_step(x, g);
         if (n < 0) begin res = 0; err = 1'b1; iters = p; return; end
         if (n == g || p == ITERS) begin res = n; err = 1'b0; iters = p; return; end
         g = n;
      end
   endfunction

   // Iteration unit model: random ready, fixed latency, one-cycle result pulse.
   initial begin : unit_model
      forever begin
         @(negedge clock);
         iter_output_valid = 1'b0;
         if (flush) begin ubusy = 1'b0; flush = 1'b0; end
         if (ubusy) begin
            iter_input_ready = 1'b0;
            if (mode != 1) begin
               ucnt--;
               if (ucnt == 0) begin
                  ubusy = 1'b0;
                  iter_output_valid = 1'b1;
                  iter_new_guess = (mode == 2) ? -unit_step(ux, ug) : unit_step(ux, ug);
               end
            end
         end
         if (!ubusy) begin
            iter_input_ready = ($urandom_range(0, 3) != 0);
            if (iter_input_valid && iter_input_ready) begin
               ubusy = 1'b1; ucnt = UNIT_LAT; ux = iter_number; ug = iter_old_guess;
            end
         end
      end
   end

   // Monitor: compare each new output_valid against the scoreboard head.
   initial begin : monitor
      logic ov_prev;
      exp_t e;
      int   diff;
      ov_prev = 1'b0;
      forever begin
         @(negedge clock);
         if (iter_input_valid) iv_count++;
         if (output_valid && !ov_prev) begin
            check("queue_has_entry", longint'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
               e = sb.pop_front();
               if (e.tol == 0) begin
                  check({e.name, "_result"}, result, e.exp_result);
               end else begin
                  tests++;
                  diff = int'(result) - e.exp_result;
                  if (diff < 0) diff = -diff;
                  if (diff > e.tol) begin
                     fails++;
                     $display("FAIL %s_result: actual %0d required %0d +/- %0d", e.name, result, e.exp_result, e.tol);
                  end
               end
               check({e.name, "_error"}, error, e.exp_error);
               check({e.name, "_iters"}, iterations_used, e.exp_iters);
               if (e.lat_mode == 1) begin
                  check({e.name, "_latency"}, cyc - e.accept_cyc, e.lat);
                  check({e.name, "_no_iter_valid"}, iv_count - e.iv_snap, 0);
               end else if (e.lat_mode == 2) begin
                  check({e.name, "_timeout_latency"}, cyc - hs_cyc, e.lat);
               end
            end
         end
         ov_prev = output_valid;
      end
   end

   task automatic send(input fixed_t x, input string name, input int exp_res, input int tol,
                       input bit exp_err, input int exp_it, input int lat_mode, input int lat);
      exp_t e;
      int   guard;
      guard = 0;
      @(negedge clock);
      while (!input_ready && guard < 2000) begin @(negedge clock); guard++; end
      if (!input_ready) begin
         check({name, "_input_ready_wait"}, input_ready, 1);
         return;
      end
      input_valid = 1'b1;
      number      = x;
      e.exp_result = exp_res; e.tol = tol; e.exp_error = exp_err; e.exp_iters = exp_it;
      e.lat_mode = lat_mode; e.lat = lat; e.accept_cyc = cyc; e.name = name;
      @(posedge clock);
      #1;
      input_valid = 1'b0;
      e.iv_snap = iv_count;
      sb.push_back(e);
   endtask

   task automatic wait_drain();
      int guard;
      guard = 0;
      while (sb.size() != 0 && guard < 3000) begin @(negedge clock); guard++; end
      if (sb.size() != 0) begin
         check("drain_pending", sb.size(), 0);
         sb.delete();
      end
      @(negedge clock);
   endtask

   initial begin : stimulus
      int r, it, snap, guard;
      bit er;
      fixed_t x;
      repeat (3) @(negedge clock);
      check("rst_input_ready", input_ready, 1);
      check("rst_output_valid", output_valid, 0);
      check("rst_error", error, 0);
      check("rst_result", result, 0);
      check("rst_iterations_used", iterations_used, 0);
      check("rst_iter_input_valid", iter_input_valid, 0);
      reset = 1'b0;

      send(32'sd262144, "x4", 32768, 0, 1'b0, 1, 0, 0);
      send(32'sd16384, "x0p25", 131072, 0, 1'b0, 1, 0, 0);
      ref_rsqrt(32'sd131072, r, er, it);
      send(32'sd131072, "x2", 46341, 2, 1'b0, it, 0, 0);
      send(32'sd0, "x0", 0, 0, 1'b1, 0, 1, 2);
      send(-32'sd65536, "xneg1", 0, 0, 1'b1, 0, 1, 2);
      wait_drain();

      mode = 1;
      send(32'sd196608, "timeout", 32768, 0, 1'b1, 0, 2, TMO + 1);
      wait_drain();
      check("timeout_input_ready", input_ready, 1);
      mode = 0; flush = 1'b1;
      repeat (2) @(negedge clock);

      // Abort a multi-pass request during the WAIT of its second pass.
      snap = hs_count;
      send(32'sd131072, "aborted", 0, 0, 1'b0, 0, 0, 0);
      guard = 0;
      while (hs_count < snap + 2 && guard < 500) begin @(negedge clock); guard++; end
      check("abort_second_pass_reached", longint'(hs_count >= snap + 2), 1);
      @(negedge clock);
      reset = 1'b1; flush = 1'b1;
      sb.delete();
      @(negedge clock);
      check("abort_input_ready", input_ready, 1);
      check("abort_output_valid", output_valid, 0);
      check("abort_iter_input_valid", iter_input_valid, 0);
      reset = 1'b0;
      send(32'sd65536, "x1", 65536, 0, 1'b0, 1, 0, 0);
      wait_drain();

      mode = 2;
      send(32'sd589824, "neg_guess", 0, 0, 1'b1, 1, 0, 0);
      wait_drain();
      mode = 0;

      // Randomised back-to-back requests over roughly 0.01 .. 100.
      for (int i = 0; i < 20; i++) begin
         x = fixed_t'($urandom_range(655, 6553600));
         ref_rsqrt(x, r, er, it);
         send(x, $sformatf("rand%0d", i), r, 0, er, it, 0, 0);
      end
      wait_drain();
      check("scoreboard_empty", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: actual still running, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
